phase_wrapper: RTL and testbench
================================

# phase_wrapper

Inverse of the phase unwrapper: integrates a stream of signed per-sample phase increments (frequency words) into a wrapped, modulo-2^DIN_WIDTH phase. It also keeps a signed count of completed turns, so downstream logic can rebuild the unwrapped phase. It sits between the frequency/demodulation path and any block that consumes wrapped phase, such as a DDS phase port or a phase-detector reference. Both streams use valid/ready handshakes with a single registered output stage.

## Interface
- DIN_WIDTH, 8, width of wrapped phase; frequency input is DIN_WIDTH+1 bits
- TURN_WIDTH, 8, width of signed turn counter
- clk  in  1  system clock, all logic on rising edge
- resetn  in  1  asynchronous, active-low reset
- acc_on  in  1  1: integrate; 0: accepted samples clear accumulator and turn count
- freq_in  in  DIN_WIDTH+1  signed phase increment, two's complement
- freq_valid  in  1  freq_in valid
- freq_ready  out  1  block accepts freq_in this cycle
- phase_out  out  DIN_WIDTH  signed wrapped phase (registered)
- phase_valid  out  1  phase_out/turns valid
- phase_ready  in  1  downstream accepts output
- turns  out  TURN_WIDTH  signed completed-turn count (registered; see Configuration)
- turn_overflow  out  1  sticky, set when turns saturates

## Operation
- Accept occurs when freq_valid && freq_ready. freq_ready = !phase_valid || phase_ready, combinational from phase_ready. No other combinational path exists.
- On accept with acc_on=1:
  - s = sext(phase_out, DIN_WIDTH+2) + sext(freq_in, DIN_WIDTH+2).
  - phase_out <= s[DIN_WIDTH-1:0].
  - delta = +1 if s > 2^(DIN_WIDTH-1)-1, -1 if s < -2^(DIN_WIDTH-1), else 0.
  - The range of s guarantees |delta| ≤ 1.
- turns <= turns + delta, saturating at signed TURN_WIDTH limits. A saturated update sets turn_overflow; turns then holds its limit.
- On accept with acc_on=0: phase_out <= 0, turns <= 0, turn_overflow <= 0, and phase_valid still asserts. This gives a restart of integration that is aligned to the handshake.
- phase_valid: set on accept; cleared when phase_ready && no accept in the same cycle.
- Simultaneous output consume and input accept: the new result loads and phase_valid stays 1. Throughput is 1 sample/cycle.
- While phase_valid && !phase_ready:
  - phase_out, turns and turn_overflow hold.
  - freq_ready = 0, and freq_in is not consumed.
- acc_on is sampled only on accept cycles.

## Timing
- Reset values: phase_out=0, turns=0, turn_overflow=0, phase_valid=0. The accumulator state is phase_out itself.
- Latency: the result of an accept at edge k is visible after edge k, with phase_valid=1 from cycle k+1.
- Reset asserted mid-stream clears all registers immediately. The first accept after deassertion integrates from phase 0.
- Wrap boundaries:
  - 127+1 → -128 with turns +1.
  - -128-1 → 127 with turns -1 (DIN_WIDTH=8).
- Extreme inputs:
  - freq_in=+255 from 0 → phase -1, turns +1.
  - freq_in=-256 from 0 → phase 0, turns -1.

## Configuration
- PHASE_WRAPPER_TURN_COUNT_EN defined: the turn counter, saturation logic and turn_overflow are built as described.
- PHASE_WRAPPER_TURN_COUNT_EN undefined:
  - turns is tied to 0 and turn_overflow is tied to 0.
  - No counter logic is synthesized.
  - Wrapped phase and handshake behaviour are unchanged.

## Test plan
- Steady integration: DIN_WIDTH=8, acc_on=1, freq_in=5 every cycle, phase_ready=1 → phase_out 5,10,…,125, then -126 with turns=1. A new result appears every cycle.
- Negative wrap: drive phase to -120, then freq_in=-10 → phase_out=126, turns decremented by 1.
- acc_on clear: after reaching phase 40 / turns 2, one accept with acc_on=0 → phase_out=0, turns=0. Next accept with freq_in=7 and acc_on=1 → 7.
- Backpressure: hold phase_ready=0 for 3 cycles with freq_valid=1 → freq_ready=0 and phase_out stable. On release, exactly one sample per cycle is accepted and no sample is lost or duplicated.
- Saturation: TURN_WIDTH=4, freq_in=+128 repeated → turns climbs to 7 and stays 7 with turn_overflow=1. An acc_on=0 accept clears both.
- Async reset: assert resetn=0 mid-stream between edges → all outputs 0 immediately. Rebuild with PHASE_WRAPPER_TURN_COUNT_EN undefined → turns and turn_overflow read 0 throughout, and phase sequence identical to the first test.

Source files
------------

// File: rtl/phase_wrapper.sv
// phase_wrapper: integrates signed per-sample phase increments into a wrapped
// modulo-2^DIN_WIDTH phase, with an optional saturating count of completed turns.
//
// Optional feature macro: PHASE_WRAPPER_TURN_COUNT_EN
//   defined   -> turn counter, saturation and turn_overflow are built
//   undefined -> turns and turn_overflow are tied to 0
//
// Ports:
//   clk           system clock, rising edge
//   resetn        asynchronous active-low reset
//   acc_on        1: integrate, 0: accepted sample clears phase/turns/overflow
//   freq_in       signed phase increment, DIN_WIDTH+1 bits
//   freq_valid    freq_in valid
//   freq_ready    block accepts freq_in this cycle (combinational from phase_ready)
//   phase_out     registered signed wrapped phase
//   phase_valid   phase_out/turns valid
//   phase_ready   downstream accepts output
//   turns         registered signed completed-turn count
//   turn_overflow sticky, set when turns saturates
module phase_wrapper #(
    parameter int unsigned DIN_WIDTH  = 8,
    parameter int unsigned TURN_WIDTH = 8
) (
    input  logic                         clk,
    input  logic                         resetn,
    input  logic                         acc_on,
    input  logic signed [DIN_WIDTH:0]    freq_in,
    input  logic                         freq_valid,
    output logic                         freq_ready,
    output logic signed [DIN_WIDTH-1:0]  phase_out,
    output logic                         phase_valid,
    input  logic                         phase_ready,
    output logic signed [TURN_WIDTH-1:0] turns,
    output logic                         turn_overflow
);

    localparam int unsigned SUM_WIDTH = DIN_WIDTH + 2;

    logic                        accept;
    logic signed [SUM_WIDTH-1:0] sum;

    // Single output stage: accept whenever it is empty or being drained.
    assign freq_ready = !phase_valid || phase_ready;
    assign accept     = freq_valid && freq_ready;

    // Sign-extended sum; the bits above the wrapped phase carry the turn delta.
    assign sum = {{2{phase_out[DIN_WIDTH-1]}}, phase_out}
               + {freq_in[DIN_WIDTH], freq_in};

    // Wrapped phase accumulator and output valid.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            phase_out   <= '0;
            phase_valid <= 1'b0;
        end else if (accept) begin
            phase_out   <= acc_on ? sum[DIN_WIDTH-1:0] : '0;
            phase_valid <= 1'b1;
        end else if (phase_ready) begin
            phase_valid <= 1'b0;
        end
    end

`ifdef PHASE_WRAPPER_TURN_COUNT_EN

    localparam int unsigned HI_WIDTH = SUM_WIDTH - DIN_WIDTH + 1;
    localparam logic signed [TURN_WIDTH-1:0] TURN_MAX = {1'b0, {(TURN_WIDTH-1){1'b1}}};
    localparam logic signed [TURN_WIDTH-1:0] TURN_MIN = {1'b1, {(TURN_WIDTH-1){1'b0}}};

    logic [HI_WIDTH-1:0] sum_hi;
    logic                wrap_up;
    logic                wrap_dn;

    // The sum fits the wrapped range iff its top bits are all equal to the sign.
    assign sum_hi  = sum[SUM_WIDTH-1:DIN_WIDTH-1];
    assign wrap_up = !sum[SUM_WIDTH-1] && (sum_hi != '0);
    assign wrap_dn =  sum[SUM_WIDTH-1] && (sum_hi != '1);

    // Saturating turn counter with sticky overflow flag.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            turns         <= '0;
            turn_overflow <= 1'b0;
        end else if (accept) begin
            if (!acc_on) begin
                turns         <= '0;
                turn_overflow <= 1'b0;
            end else if (wrap_up) begin
                if (turns == TURN_MAX) begin
                    turn_overflow <= 1'b1;
                end else begin
                    turns <= turns + TURN_WIDTH'(1);
                end
            end else if (wrap_dn) begin
                if (turns == TURN_MIN) begin
                    turn_overflow <= 1'b1;
                end else begin
                    turns <= turns - TURN_WIDTH'(1);
                end
            end
        end
    end

`else

    // Upper sum bits only feed the turn counter, which is not built here.
    logic unused_sum_hi;
    assign unused_sum_hi = ^sum[SUM_WIDTH-1:DIN_WIDTH];

    assign turns         = '0;
    assign turn_overflow = 1'b0;

`endif

endmodule

// File: tb/tb_phase_wrapper.sv
// tb_phase_wrapper: directed and randomized stimulus for phase_wrapper, checked
// against an arithmetic reference model (unwrapped sum, modulo wrap, turn count).
module tb_phase_wrapper;

    localparam int DW     = 8;
    localparam int TW     = 4;
    localparam int MODV   = 1 << DW;
    localparam int PH_MAX = (1 << (DW - 1)) - 1;
    localparam int T_MAX  = (1 << (TW - 1)) - 1;
    localparam int T_MIN  = -(1 << (TW - 1));
`ifdef PHASE_WRAPPER_TURN_COUNT_EN
    localparam bit TC_EN = 1'b1;
`else
    localparam bit TC_EN = 1'b0;
`endif

    logic                 clk = 1'b0;
    logic                 resetn;
    logic                 acc_on;
    logic signed [DW:0]   freq_in;
    logic                 freq_valid;
    logic                 freq_ready;
    logic signed [DW-1:0] phase_out;
    logic                 phase_valid;
    logic                 phase_ready;
    logic signed [TW-1:0] turns;
    logic                 turn_overflow;

    int tests = 0;
    int fails = 0;

    // Reference model state
    int m_phase = 0;
    int m_turns = 0;
    bit m_ovf   = 1'b0;
    bit m_pv    = 1'b0;

    phase_wrapper #(.DIN_WIDTH(DW), .TURN_WIDTH(TW)) dut (
        .clk           (clk),
        .resetn        (resetn),
        .acc_on        (acc_on),
        .freq_in       (freq_in),
        .freq_valid    (freq_valid),
        .freq_ready    (freq_ready),
        .phase_out     (phase_out),
        .phase_valid   (phase_valid),
        .phase_ready   (phase_ready),
        .turns         (turns),
        .turn_overflow (turn_overflow)
    );

    always #5 clk = ~clk;

    function automatic int wrap(input int v);
        int m;
        m = v & (MODV - 1);
        return (m > PH_MAX) ? m - MODV : m;
    endfunction

    task automatic check(input string tag, input logic signed [31:0] obs,
                         input logic signed [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d required %0d", tag, obs, exp);
        end
    endtask

    task automatic check_outputs(input string tag);
        check({tag, ".phase"}, phase_out, m_phase);
        check({tag, ".valid"}, phase_valid, m_pv);
        check({tag, ".turns"}, turns, TC_EN ? m_turns : 0);
        check({tag, ".ovf"}, turn_overflow, TC_EN ? m_ovf : 1'b0);
    endtask

    task automatic model_reset();
        m_phase = 0;
        m_turns = 0;
        m_ovf   = 1'b0;
        m_pv    = 1'b0;
    endtask

    // One clock: drive inputs, check ready, clock, update model, check outputs.
    task automatic cycle(input string tag, input bit fv, input int f,
                         input bit acc, input bit pr);
        bit rdy;
        bit acc_ok;
        int raw;
        int nt;
        freq_valid  = fv;
        freq_in     = (DW + 1)'(f);
        acc_on      = acc;
        phase_ready = pr;
        #1;
        rdy = !m_pv || pr;
        check({tag, ".ready"}, freq_ready, rdy);
        acc_ok = fv && rdy;
        @(posedge clk);
        if (acc_ok) begin
            if (acc) begin
                raw     = m_phase + f;
                m_phase = wrap(raw);
                nt      = m_turns + (raw - m_phase) / MODV;
                if (nt > T_MAX) begin
                    m_turns = T_MAX;
                    m_ovf   = 1'b1;
                end else if (nt < T_MIN) begin
                    m_turns = T_MIN;
                    m_ovf   = 1'b1;
                end else begin
                    m_turns = nt;
                end
            end else begin
                m_phase = 0;
                m_turns = 0;
                m_ovf   = 1'b0;
            end
            m_pv = 1'b1;
        end else if (pr) begin
            m_pv = 1'b0;
        end
        #1;
        check_outputs(tag);
    endtask

    initial begin
        resetn      = 1'b0;
        acc_on      = 1'b1;
        freq_in     = '0;
        freq_valid  = 1'b0;
        phase_ready = 1'b1;
        #1;
        check_outputs("reset");
        #12;
        resetn = 1'b1;

        // Steady integration of +5: 5..125, then -126 with one turn
        for (int i = 1; i <= 26; i++) cycle("steady", 1'b1, 5, 1'b1, 1'b1);
        check("steady_end.phase", phase_out, -126);
        check("steady_end.turns", turns, TC_EN ? 1 : 0);

        // Negative wrap: -120 - 10 -> 126, turns -1
        cycle("clr", 1'b1, 0, 1'b0, 1'b1);
        cycle("neg", 1'b1, -120, 1'b1, 1'b1);
        cycle("neg", 1'b1, -10, 1'b1, 1'b1);
        check("negwrap.phase", phase_out, 126);
        check("negwrap.turns", turns, TC_EN ? -1 : 0);

        // Reach phase 40 / turns 2, clear with acc_on=0, restart with 7
        cycle("clr", 1'b1, 0, 1'b0, 1'b1);
        cycle("build", 1'b1, 255, 1'b1, 1'b1);
        cycle("build", 1'b1, 255, 1'b1, 1'b1);
        cycle("build", 1'b1, 42, 1'b1, 1'b1);
        check("build.phase", phase_out, 40);
        check("build.turns", turns, TC_EN ? 2 : 0);
        cycle("accoff", 1'b1, 99, 1'b0, 1'b1);
        check("accoff.phase", phase_out, 0);
        cycle("restart", 1'b1, 7, 1'b1, 1'b1);
        check("restart.phase", phase_out, 7);

        // Backpressure: three stalled cycles, then one accept per cycle
        for (int i = 0; i < 3; i++) cycle("stall", 1'b1, 3, 1'b1, 1'b0);
        check("stall.phase", phase_out, 7);
        for (int i = 0; i < 4; i++) cycle("drain", 1'b1, 3, 1'b1, 1'b1);
        check("drain.phase", phase_out, 19);
        cycle("idle", 1'b0, 0, 1'b1, 1'b1);

        // Extreme increments from phase 0
        cycle("clr", 1'b1, 0, 1'b0, 1'b1);
        cycle("xpos", 1'b1, 255, 1'b1, 1'b1);
        check("xpos.phase", phase_out, -1);
        check("xpos.turns", turns, TC_EN ? 1 : 0);
        cycle("clr", 1'b1, 0, 1'b0, 1'b1);
        cycle("xneg", 1'b1, -256, 1'b1, 1'b1);
        check("xneg.phase", phase_out, 0);
        check("xneg.turns", turns, TC_EN ? -1 : 0);

        // Saturation of the turn counter and clearing via acc_on=0
        cycle("clr", 1'b1, 0, 1'b0, 1'b1);
        for (int i = 0; i < 20; i++) cycle("sat", 1'b1, 128, 1'b1, 1'b1);
        check("sat.turns", turns, TC_EN ? T_MAX : 0);
        check("sat.ovf", turn_overflow, TC_EN ? 1 : 0);
        cycle("satclr", 1'b1, 5, 1'b0, 1'b1);
        check("satclr.turns", turns, 0);
        check("satclr.ovf", turn_overflow, 0);

        // Randomized traffic with random backpressure and occasional clears
        for (int i = 0; i < 400; i++) begin
            cycle("rand", $urandom_range(0, 3) != 0,
                  int'($urandom_range(0, 511)) - 256,
                  $urandom_range(0, 15) != 0,
                  $urandom_range(0, 3) != 0);
        end

        // Asynchronous reset between edges, then repeat the steady sequence
        cycle("pre_rst", 1'b1, 50, 1'b1, 1'b1);
        resetn = 1'b0;
        #1;
        model_reset();
        check_outputs("async_rst");
        #2;
        resetn = 1'b1;
        for (int i = 1; i <= 26; i++) cycle("steady2", 1'b1, 5, 1'b1, 1'b1);
        check("steady2_end.phase", phase_out, -126);
        check("steady2_end.turns", turns, TC_EN ? 1 : 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
